ifetch_unit: RTL and testbench
==============================

// Module: ifetch_unit
// PURPOSE
//  Instruction fetch stage feeding the single-port no-change instruction BRAM.
//  Holds the PC, issues 1-cycle-latency reads, and presents {PC, instruction} to decode over a valid/ready handshake.
//  Absorbs decode stalls by gating the BRAM enable; no-change mode holds RDATA, so no skid buffer is needed.
//  Accepts redirects (branch/jump/trap) and raises fetch faults for misaligned or out-of-range PCs.
// PARAMETERS
//  ADDR_WIDTH  10          byte-address width of the instruction BRAM (2**(ADDR_WIDTH-2) words)
//  RESET_PC    32'h0000_0000  first fetch address after reset
// PORTS
//  CLK           in   1           clock, all state on rising edge
//  RST           in   1           synchronous reset, active-high
//  IMEM_EN       out  1           BRAM read enable
//  IMEM_ADDR     out  ADDR_WIDTH  BRAM byte address (fetch_addr[ADDR_WIDTH-1:0])
//  IMEM_RDATA    in   32          BRAM read data, valid the cycle after IMEM_EN, held while EN=0
//  REDIRECT_VALID in  1           redirect request, single-cycle pulse or level
//  REDIRECT_PC   in   32          redirect target byte address
//  IF_VALID      out  1           fetch record presented to decode
//  IF_READY      in   1           decode accepts the record this cycle
//  IF_PC         out  32          PC of the presented record
//  IF_INSTR      out  32          instruction word (32'h0 when IF_FAULT)
//  IF_FAULT      out  1           record is a fetch fault (misaligned or out of range)
// BEHAVIOUR
//  Registers: pc_q (next PC), req_q (read issued last cycle), req_pc_q, fault_pc_q, state in {RUN, FAULT, HALT}.
//  Reset (RST=1 at edge): pc_q=RESET_PC, req_q=0, state=RUN. While RST is high: IMEM_EN=0, IF_VALID=0, IF_FAULT=0.
//  fetch_addr = REDIRECT_VALID ? REDIRECT_PC : pc_q.
//  bad = |fetch_addr[1:0] | |fetch_addr[31:ADDR_WIDTH].
//  IF_VALID = ~REDIRECT_VALID & ((state==RUN & req_q) | state==FAULT). A redirect squashes the record presented that cycle.
//  IF_PC = (state==FAULT) ? fault_pc_q : req_pc_q. IF_INSTR = (state==RUN) ? IMEM_RDATA : 0. IF_FAULT = (state==FAULT).
//  stall = IF_VALID & ~IF_READY. While stalled, no register changes and IMEM_EN=0, so RDATA and the outputs hold.
//  RUN, no stall:
//   - ~bad: IMEM_EN=1, req_q<=1, req_pc_q<=fetch_addr, pc_q<=fetch_addr+4.
//   - bad: IMEM_EN=0, req_q<=0, fault_pc_q<=fetch_addr, state<=FAULT.
//  FAULT: presents the fault record; on accept (IF_READY, no redirect) -> HALT, IMEM_EN=0.
//  HALT: IF_VALID=0, no fetches; stays until a redirect.
//  FAULT/HALT with REDIRECT_VALID: handled exactly as RUN no-stall on REDIRECT_PC, so the next state is RUN or FAULT.
//  Latency: record for an address is valid the cycle after its IMEM_EN. Throughput is 1 record/cycle with IF_READY held high.
//  Redirect with IF_READY=0: redirect wins, because IF_VALID is forced 0 and therefore stall=0.
//  Top-of-memory wrap: after (2**ADDR_WIDTH)-4 the PC becomes 2**ADDR_WIDTH, which faults; the PC never silently wraps.
//  Reset mid-stream: any in-flight read is dropped; fetch restarts at RESET_PC the cycle after RST deasserts.
//  IMEM_ADDR is don't-care when IMEM_EN=0 (drive fetch_addr truncated).
// TESTING (ADDR_WIDTH=10, RESET_PC=0, BRAM word i preloaded 32'h1000_0000+i)
//  1 Reset release, READY=1 -> EN=1 addr 0 on first cycle; next cycle VALID PC=0 INSTR=10000000, then PC 4, 8 back-to-back.
//  2 READY=0 for 3 cycles while PC=8 presented -> EN=0, PC/INSTR hold 8/10000002; after release, next record is PC=C.
//  3 REDIRECT 0x100 during stall at PC=8 -> that cycle VALID=0, PC=8 is never accepted; next record PC=100 INSTR=10000040.
//  4 REDIRECT 0x102 -> no EN; next cycle VALID=1 FAULT=1 PC=102; after accept VALID=0 (HALT); REDIRECT 0 resumes at PC=0.
//  5 REDIRECT 0x3F8 then free-run -> records 3F8, 3FC, then FAULT record PC=400 with no BRAM access.
//  6 RST pulsed with PC=20 in flight -> VALID=0 during reset; first record after release is PC=0.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch stage for a single-port, no-change instruction BRAM.
// Holds the PC and issues 1-cycle-latency reads. Each {PC, instruction}
// record goes to decode over a valid/ready handshake. A decode stall
// gates the BRAM enable; the BRAM then holds RDATA, so no skid buffer is
// needed. Misaligned or out-of-range fetch addresses produce a single fault
// record. The stage then halts until a redirect arrives.
module ifetch_unit #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic                  IMEM_EN,
  output logic [ADDR_WIDTH-1:0] IMEM_ADDR,
  input  logic [31:0]           IMEM_RDATA,
  input  logic                  REDIRECT_VALID,
  input  logic [31:0]           REDIRECT_PC,
  output logic                  IF_VALID,
  input  logic                  IF_READY,
  output logic [31:0]           IF_PC,
  output logic [31:0]           IF_INSTR,
  output logic                  IF_FAULT
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FAULT = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] fault_pc_q, fault_pc_d;

  logic [31:0] fetch_addr;
  logic        bad;
  logic        stall;
  logic        do_fetch;

  // A redirect overrides the sequential PC. The address is bad if it is
  // not word-aligned or if it lies beyond the BRAM.
  always_comb begin
    fetch_addr = REDIRECT_VALID ? REDIRECT_PC : pc_q;
    bad        = (|fetch_addr[1:0]) | (|fetch_addr[31:ADDR_WIDTH]);
  end

  // Drive the decode-facing record. A redirect squashes the record
  // presented in the same cycle.
  always_comb begin
    IF_VALID = ~RST & ~REDIRECT_VALID &
               (((state_q == RUN) & req_q) | (state_q == FAULT));
    IF_FAULT = ~RST & (state_q == FAULT);
    IF_PC    = (state_q == FAULT) ? fault_pc_q : req_pc_q;
    IF_INSTR = (state_q == RUN) ? IMEM_RDATA : 32'h0;
    stall    = IF_VALID & ~IF_READY;
    IMEM_ADDR = fetch_addr[ADDR_WIDTH-1:0];
  end

  // Compute the next state and the BRAM enable. A stall freezes everything,
  // so the held RDATA keeps the outputs stable.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    req_pc_d   = req_pc_q;
    fault_pc_d = fault_pc_q;
    IMEM_EN    = 1'b0;
    do_fetch   = 1'b0;

    if (!RST) begin
      unique case (state_q)
        RUN:     do_fetch = ~stall;
        FAULT: begin
          if (REDIRECT_VALID)  do_fetch = 1'b1;
          else if (IF_READY)   state_d  = HALT;
        end
        HALT:    do_fetch = REDIRECT_VALID;
        default: state_d  = RUN;
      endcase

      if (do_fetch) begin
        if (!bad) begin
          IMEM_EN  = 1'b1;
          req_d    = 1'b1;
          req_pc_d = fetch_addr;
          pc_d     = fetch_addr + 32'd4;
          state_d  = RUN;
        end else begin
          // The PC is never wrapped. A fetch past the top of memory becomes
          // a fault record, and no BRAM access is made.
          req_d      = 1'b0;
          fault_pc_d = fetch_addr;
          state_d    = FAULT;
        end
      end
    end
  end

  // State registers with synchronous reset. A read in flight at reset
  // is dropped.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments, so every
    // register samples values from before the edge.
    if (RST) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      req_pc_q   <= 32'h0;
      fault_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      req_pc_q   <= req_pc_d;
      fault_pc_q <= fault_pc_d;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit. It runs a directed sequence with literal
// expectations, then a randomized phase. A record-level model checks every
// cycle. The model tracks the presented record, the next sequential
// PC and a halted flag.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ifetch_unit #(.ADDR_WIDTH(10), .RESET_PC(32'h0)) dut (
    .CLK            (clk),
    .RST            (rst),
    .IMEM_EN        (imem_en),
    .IMEM_ADDR      (imem_addr),
    .IMEM_RDATA     (imem_rdata),
    .REDIRECT_VALID (redir),
    .REDIRECT_PC    (redir_pc),
    .IF_VALID       (if_valid),
    .IF_READY       (if_ready),
    .IF_PC          (if_pc),
    .IF_INSTR       (if_instr),
    .IF_FAULT       (if_fault)
  );

  always #5 clk = ~clk;

  // No-change BRAM: word i holds 0x1000_0000 + i, and the read data holds
  // while the enable is low.
  logic [31:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr >> 2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    return (a % 4 == 0) && (a < 32'h400);
  endfunction

  // Model state: the record decode would see, the next sequential PC,
  // and whether the stage is halted after an accepted fault.
  bit          have_rec = 1'b0;
  bit          rec_fault = 1'b0;
  logic [31:0] rec_pc = 32'h0;
  logic [31:0] next_pc = 32'h0;
  bit          halted = 1'b0;

  bit          m_valid, m_fault, m_stall, m_fetch, m_en;
  logic [31:0] m_target;

  // Compare on the falling edge. Inputs are stable from here until the
  // next rising edge, so the model then advances to the post-edge state.
  always @(negedge clk) begin
    m_valid  = !rst && !redir && have_rec;
    m_fault  = !rst && have_rec && rec_fault;
    m_stall  = m_valid && !if_ready;
    m_target = redir ? redir_pc : next_pc;
    m_fetch  = !rst && !m_stall && (redir || (!halted && !(have_rec && rec_fault)));
    m_en     = m_fetch && addr_ok(m_target);

    check("valid", {31'h0, if_valid}, {31'h0, m_valid});
    check("fault", {31'h0, if_fault}, {31'h0, m_fault});
    check("en",    {31'h0, imem_en},  {31'h0, m_en});
    if (m_en) check("addr", {22'h0, imem_addr}, {22'h0, m_target[9:0]});
    if (m_valid) begin
      check("pc", if_pc, rec_pc);
      check("instr", if_instr, rec_fault ? 32'h0 : 32'h1000_0000 + (rec_pc >> 2));
    end

    if (rst) begin
      have_rec = 1'b0; next_pc = 32'h0; halted = 1'b0;
    end else if (m_stall) begin
      // Everything holds.
    end else if (m_fetch) begin
      have_rec  = 1'b1;
      rec_pc    = m_target;
      rec_fault = !addr_ok(m_target);
      halted    = 1'b0;
      if (addr_ok(m_target)) next_pc = m_target + 4;
    end else if (have_rec && rec_fault && if_ready) begin
      have_rec = 1'b0;
      halted   = 1'b1;
    end
  end

  // One cycle: drive the inputs just after the rising edge, then return
  // just after the following falling edge so that outputs can be inspected.
  task automatic step(input bit r, input bit rv, input logic [31:0] rp, input bit rdy);
    @(posedge clk); #1;
    rst = r; redir = rv; redir_pc = rp; if_ready = rdy;
    @(negedge clk); #1;
  endtask

  logic [31:0] tgt;

  initial begin
    // Reset, then release with decode ready.
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    check("rst_valid", {31'h0, if_valid}, 32'h0);
    step(0, 0, 0, 1);
    check("t1_en", {31'h0, imem_en}, 32'h1);
    check("t1_addr", {22'h0, imem_addr}, 32'h0);
    step(0, 0, 0, 1);
    check("t1_pc0", if_pc, 32'h0);
    check("t1_instr0", if_instr, 32'h1000_0000);
    step(0, 0, 0, 1);
    check("t1_pc4", if_pc, 32'h4);
    // Stall while PC 8 is presented.
    step(0, 0, 0, 0);
    check("t2_pc8", if_pc, 32'h8);
    check("t2_en0", {31'h0, imem_en}, 32'h0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("t2_hold", if_instr, 32'h1000_0002);
    // A redirect during the stall wins and squashes PC 8.
    step(0, 1, 32'h100, 0);
    check("t3_squash", {31'h0, if_valid}, 32'h0);
    step(0, 0, 0, 1);
    check("t3_pc", if_pc, 32'h100);
    check("t3_instr", if_instr, 32'h1000_0040);
    // Misaligned redirect gives a fault, then HALT, then resume at 0.
    step(0, 1, 32'h102, 1);
    check("t4_noen", {31'h0, imem_en}, 32'h0);
    step(0, 0, 0, 1);
    check("t4_fault", {31'h0, if_fault}, 32'h1);
    check("t4_fpc", if_pc, 32'h102);
    step(0, 0, 0, 1);
    check("t4_halt", {31'h0, if_valid}, 32'h0);
    step(0, 1, 32'h0, 1);
    step(0, 0, 0, 1);
    check("t4_resume", if_pc, 32'h0);
    // Top of memory: 3F8, 3FC, then a fault at 400 with no BRAM access.
    step(0, 1, 32'h3F8, 1);
    step(0, 0, 0, 1);
    check("t5_3f8", if_pc, 32'h3F8);
    step(0, 0, 0, 1);
    check("t5_3fc", if_pc, 32'h3FC);
    check("t5_noen", {31'h0, imem_en}, 32'h0);
    step(0, 0, 0, 1);
    check("t5_fpc", if_pc, 32'h400);
    check("t5_fault", {31'h0, if_fault}, 32'h1);
    // Reset with PC 0x20 in flight.
    step(0, 1, 32'h20, 1);
    step(1, 0, 0, 1);
    check("t6_rstvalid", {31'h0, if_valid}, 32'h0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("t6_pc", if_pc, 32'h0);

    // Randomized phase.
    for (int c = 0; c < 4000; c++) begin
      case ($urandom_range(0, 3))
        0:       tgt = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        1:       tgt = 32'h3F0 + 4 * $urandom_range(0, 3);
        2:       tgt = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        default: tgt = ($urandom_range(0, 1) != 0) ? 32'h400 + 4 * $urandom_range(0, 64)
                                                   : 32'h8000_0000 | $urandom;
      endcase
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, tgt,
           $urandom_range(0, 9) < 7);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
